bram_port_initiator: RTL
========================

Name: bram_port_initiator

Overview:
- Initiator that drives one port of the team's dual-port BRAM wrappers: address, write data, write mask, write enable and chip enable, plus read data coming back.
- Converts a valid/ready request stream from an accelerator datapath into legal single-port BRAM cycles, and returns read data on a valid/ready response stream.
- The BRAM primitive ignores per-bit write masks, so partial-mask writes are done here as read-modify-write (RMW).
- One instance sits between each accelerator port and one BRAM port.

Parameters:
ADDR_W, 10, address width (1024-entry BRAM)
DATA_W, 16, data width
RSP_DEPTH, 2, response FIFO entries (>=2)

Ports:
CLK  in  1  clock; memory and logic share it
RST  in  1  reset; asynchronous, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid&&req_ready
req_addr  in  ADDR_W  word address
req_we  in  1  1=write, 0=read
req_wdata  in  DATA_W  write data
req_wmask  in  DATA_W  per-bit write enable
rsp_valid  out  1  read data available
rsp_ready  in  1  consumer pops the response
rsp_rdata  out  DATA_W  read data, in request order
A  out  ADDR_W  BRAM address
D  out  DATA_W  BRAM write data
WE  out  1  BRAM write enable
WEM  out  DATA_W  BRAM mask; all-ones whenever WE=1, else 0
CE  out  1  BRAM enable
Q  in  DATA_W  BRAM read data; valid the cycle after a CE&&!WE cycle
busy  out  1  state!=IDLE or read in flight or FIFO non-empty

Behaviour:
- Reset (async, RST=1): state=IDLE and in-flight flag=0.
  - FIFO is emptied.
  - All outputs go to 0 immediately: req_ready, rsp_valid, CE, WE, WEM, A, D, busy, rsp_rdata.
- State IDLE:
  - req_ready=1 when credit_ok.
  - credit_ok is defined as: fifo_count + inflight - (rsp_valid&&rsp_ready) < RSP_DEPTH.
  - Memory outputs are combinational from the accepted request in the same cycle.
- Read accepted in cycle N:
  - Cycle N: CE=1, WE=0, A=req_addr.
  - Cycle N+1: inflight=1; Q is pushed into the FIFO at the end of N+1.
  - Cycle N+2: rsp_valid=1. Response latency is 2 cycles when the FIFO is empty.
  - Sustains one read per cycle while rsp_ready=1.
- Write with req_wmask all-ones: CE=1, WE=1, D=req_wdata in the accept cycle. No response is generated. Stays in IDLE.
- Write with req_wmask==0: accepted, no memory cycle (CE=0), no response.
- Write with a partial mask:
  - Accept cycle: CE=1, WE=0 (read of the old word). Latch addr, wdata, wmask. Go to RMW_WR.
  - RMW_WR (next cycle): req_ready=0. CE=1, WE=1, A=latched addr, D=(Q&~wmask)|(wdata&wmask). Go to IDLE.
  - Partial writes cost 2 cycles; req_ready is low for exactly 1 cycle.
- An RMW read never consumes a FIFO credit or produces a response.
- Ordering: requests are served strictly in order. A read after a write to the same address returns the new data (serial port, no bypass needed).
- FIFO:
  - Full: credit_ok gates new reads; writes are still accepted.
  - Empty: rsp_valid=0.
  - Simultaneous push and pop keeps the count unchanged.
  - Count wraps modulo RSP_DEPTH pointers.
- Reset during RMW_WR: the write is abandoned, WE drops asynchronously, memory keeps its old value.

Decomposition:
- Shared package bram_if_pkg holds:
  - ADDR_W/DATA_W defaults;
  - state enum {IDLE, RMW_WR};
  - the merge function (old, new, mask).
- One sub-module: bram_rsp_fifo (DATA_W, RSP_DEPTH, push/pop/count, async active-high reset).

Test Plan:
1. Full write 0xABCD @5 in cycle 0, read @5 in cycle 1 with rsp_ready=1 -> rsp_valid in cycle 3, rsp_rdata=0xABCD, CE high in cycles 0 and 1.
2. Preload 0xABCD @7, then write 0x1234 with mask 0x00FF -> WE pulses exactly 1 cycle later with D=0xAB34; req_ready low for 1 cycle; a subsequent read returns 0xAB34.
3. rsp_ready=0, issue 3 reads (addresses 1, 2, 3) -> only 2 accepted; after one pop the third is accepted; responses arrive in order 1, 2, 3.
4. Write with mask 0x0000 @9 -> CE stays 0, req_ready stays 1, later read @9 returns the unchanged value.
5. Assert RST in the RMW_WR cycle -> WE=0 in that cycle (async), memory word unchanged, all outputs 0, busy=0.
6. Back-to-back reads @0..7 with rsp_ready=1 -> 8 responses, 1 per cycle from cycle 2, in address order, req_ready never drops.

Source files
------------

// File: rtl/bram_if_pkg.sv
// Shared definitions for the BRAM port initiator: default widths, FSM states
// and the masked merge used by read-modify-write.
package bram_if_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 16;
  localparam int MERGE_W    = 64;

  typedef enum logic {
    IDLE,
    RMW_WR
  } state_t;

  // Bits set in mask take the new value, the rest keep the old word.
  function automatic logic [MERGE_W-1:0] merge(input logic [MERGE_W-1:0] old_w,
                                               input logic [MERGE_W-1:0] new_w,
                                               input logic [MERGE_W-1:0] mask);
    return (old_w & ~mask) | (new_w & mask);
  endfunction

endpackage

// File: rtl/bram_rsp_fifo.sv
// Small circular response FIFO; head word is presented while non-empty.
module bram_rsp_fifo #(
  parameter int DATA_W    = 16,
  parameter int RSP_DEPTH = 2,
  parameter int CNT_W     = $clog2(RSP_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic [CNT_W-1:0]  count
);

  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

  logic [DATA_W-1:0] mem [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop, empty;

  assign empty    = (count == '0);
  assign do_pop   = pop && !empty;
  assign do_push  = push && ((count != CNT_W'(RSP_DEPTH)) || do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < RSP_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= (wr_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      end
      if (do_pop)
        rd_ptr <= (rd_ptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bram_port_initiator.sv
// Turns a valid/ready request stream into single-port BRAM cycles, doing
// partial-mask writes as read-modify-write, and returns reads in order.
module bram_port_initiator
  import bram_if_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RSP_DEPTH = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [DATA_W-1:0] req_wmask,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              WE,
  output logic [DATA_W-1:0] WEM,
  output logic              CE,
  input  logic [DATA_W-1:0] Q,
  output logic              busy
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int OCC_W = CNT_W + 1;

  state_t            state_q, state_d;
  logic              inflight_q;
  logic [ADDR_W-1:0] rmw_addr_q;
  logic [DATA_W-1:0] rmw_wdata_q, rmw_wmask_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [OCC_W-1:0]  occ;
  logic              credit_ok, fire, rd_issue, lat_en, pop;

  assign rsp_valid = (fifo_count != '0);
  assign pop       = rsp_valid && rsp_ready;
  // Occupancy counts the read whose data lands in the FIFO this cycle.
  assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight_q) - OCC_W'(pop);
  assign credit_ok = (occ < OCC_W'(RSP_DEPTH));
  assign busy      = (state_q != IDLE) || inflight_q || rsp_valid;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    fire      = 1'b0;
    rd_issue  = 1'b0;
    lat_en    = 1'b0;
    CE        = 1'b0;
    WE        = 1'b0;
    A         = '0;
    D         = '0;
    // Reset forces the combinational outputs low as well as the registers.
    if (!RST) begin
      case (state_q)
        IDLE: begin
          req_ready = credit_ok || req_we;
          fire      = req_valid && req_ready;
          if (fire) begin
            if (!req_we) begin
              CE       = 1'b1;
              A        = req_addr;
              rd_issue = 1'b1;
            end else if (req_wmask == '1) begin
              CE = 1'b1;
              WE = 1'b1;
              A  = req_addr;
              D  = req_wdata;
            end else if (req_wmask != '0) begin
              CE      = 1'b1;
              A       = req_addr;
              lat_en  = 1'b1;
              state_d = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          CE      = 1'b1;
          WE      = 1'b1;
          A       = rmw_addr_q;
          D       = DATA_W'(merge(MERGE_W'(Q), MERGE_W'(rmw_wdata_q), MERGE_W'(rmw_wmask_q)));
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
    WEM = {DATA_W{WE}};
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= IDLE;
      inflight_q  <= 1'b0;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_wmask_q <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= rd_issue;
      if (lat_en) begin
        rmw_addr_q  <= req_addr;
        rmw_wdata_q <= req_wdata;
        rmw_wmask_q <= req_wmask;
      end
    end
  end

  bram_rsp_fifo #(
    .DATA_W   (DATA_W),
    .RSP_DEPTH(RSP_DEPTH),
    .CNT_W    (CNT_W)
  ) u_rsp_fifo (
    .clk      (CLK),
    .rst      (RST),
    .push     (inflight_q),
    .push_data(Q),
    .pop      (pop),
    .pop_data (rsp_rdata),
    .count    (fifo_count)
  );

endmodule
